// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN streaming blocks (serial_to_parallel,
// parallel_to_serial).
//
// Contents:
//   DATA_W_DEFAULT  default width of one signed sample
//   NUM_CH          number of samples per group (fixed)
//   idx_t           sample index counter type (2 bits; value 3 is unused)
//   IDX_FIRST       index of channel 0
//   IDX_LAST        index of the final channel in a group
//   next_idx()      advance an index with wrap to channel 0
package cnn_pkg;

    parameter int DATA_W_DEFAULT = 8;
    localparam int NUM_CH = 3;

    typedef logic [1:0] idx_t;

    localparam idx_t IDX_FIRST = 2'd0;
    localparam idx_t IDX_LAST  = idx_t'(NUM_CH - 1);

    // Advance the index by one accepted sample. Wrapping from IDX_LAST goes to
    // channel 0, and the unused code 3 also falls back to channel 0.
    function automatic idx_t next_idx(input idx_t idx);
        idx_t nxt;
        if (idx >= IDX_LAST) begin
            nxt = IDX_FIRST;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/serial_to_parallel_if.sv
// Bus bundle between a serial sample source and serial_to_parallel.
//
// Signals:
//   din     serial sample, signed DATA_W (source -> block)
//   vin     sample valid, one sample per cycle while high (source -> block)
//   sof     start-of-group marker, meaningful only with vin (source -> block)
//   dout_0  channel 0 sample of the last completed group (block -> sink)
//   dout_1  channel 1 sample of the last completed group (block -> sink)
//   dout_2  channel 2 sample of the last completed group (block -> sink)
//   vout_0  group-complete pulse, channel 0 (block -> sink)
//   vout_1  group-complete pulse, channel 1 (block -> sink)
//   vout_2  group-complete pulse, channel 2 (block -> sink)
//   err     partial-group-discarded pulse (block -> sink)
//
// Modports:
//   master  the side that drives the serial stream and observes the group
//   slave   the serial_to_parallel block itself
interface serial_to_parallel_if
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic signed [DATA_W-1:0] din;
    logic                     vin;
    logic                     sof;

    logic signed [DATA_W-1:0] dout_0;
    logic signed [DATA_W-1:0] dout_1;
    logic signed [DATA_W-1:0] dout_2;
    logic                     vout_0;
    logic                     vout_1;
    logic                     vout_2;
    logic                     err;

    modport master (
        output din,
        output vin,
        output sof,
        input  dout_0,
        input  dout_1,
        input  dout_2,
        input  vout_0,
        input  vout_1,
        input  vout_2,
        input  err
    );

    modport slave (
        input  din,
        input  vin,
        input  sof,
        output dout_0,
        output dout_1,
        output dout_2,
        output vout_0,
        output vout_1,
        output vout_2,
        output err
    );

endinterface

// File: rtl/serial_to_parallel.sv
// Collects a serial stream of signed samples into groups of NUM_CH (3)
// parallel channels.
//
// Ports:
//   clk  sole clock, all state updates on the rising edge
//   rst  synchronous active-high reset, priority over all inputs
//   bus  serial_to_parallel_if slave modport:
//          din/vin/sof in; dout_0..2, vout_0..2, err out
//
// Behaviour:
//   Each accepted sample (vin=1) is stored in the slot given by the index
//   counter. Channels 0 and 1 wait in buf_0/buf_1; when channel 2 arrives the
//   whole group is moved to dout_0..2 and vout_0..2 pulse for one cycle.
//   A sof on a sample while a group is partly filled discards that partial
//   group, pulses err, and restarts the group with the sof sample as
//   channel 0. There is no backpressure. All outputs are registered.
module serial_to_parallel
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    serial_to_parallel_if.slave bus
);

    idx_t                     idx_q;
    logic signed [DATA_W-1:0] buf_0_q;
    logic signed [DATA_W-1:0] buf_1_q;

    // A group is partly filled only at index 1 or 2; the unused code 3 is
    // treated as empty so a sof there just restarts without an error.
    logic partial;
    assign partial = (idx_q == 2'd1) || (idx_q == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= IDX_FIRST;
            buf_0_q    <= '0;
            buf_1_q    <= '0;
            bus.dout_0 <= '0;
            bus.dout_1 <= '0;
            bus.dout_2 <= '0;
            bus.vout_0 <= 1'b0;
            bus.vout_1 <= 1'b0;
            bus.vout_2 <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            // Pulses are single-cycle; they clear unless set again below.
            bus.vout_0 <= 1'b0;
            bus.vout_1 <= 1'b0;
            bus.vout_2 <= 1'b0;
            bus.err    <= 1'b0;

            if (bus.vin) begin
                if (bus.sof && partial) begin
                    // Resynchronise: drop the partial group, keep this sample.
                    bus.err <= 1'b1;
                    buf_0_q <= bus.din;
                    idx_q   <= 2'd1;
                end else begin
                    case (idx_q)
                        2'd0: begin
                            buf_0_q <= bus.din;
                            idx_q   <= next_idx(idx_q);
                        end
                        2'd1: begin
                            buf_1_q <= bus.din;
                            idx_q   <= next_idx(idx_q);
                        end
                        2'd2: begin
                            bus.dout_0 <= buf_0_q;
                            bus.dout_1 <= buf_1_q;
                            bus.dout_2 <= bus.din;
                            bus.vout_0 <= 1'b1;
                            bus.vout_1 <= 1'b1;
                            bus.vout_2 <= 1'b1;
                            idx_q      <= next_idx(idx_q);
                        end
                        default: begin
                            // Unreachable code 3: recover to channel 0.
                            idx_q <= IDX_FIRST;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
module tb_serial_to_parallel;

    localparam int W = 8;

    logic clk;
    logic rst;

    int n_cmp;
    int n_fail;

    serial_to_parallel_if #(.DATA_W(W)) bus ();

    serial_to_parallel #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for exactly one edge, then go idle.
    task automatic send(input logic signed [W-1:0] d, input logic s);
        bus.din = d;
        bus.sof = s;
        bus.vin = 1'b1;
        tick();
        bus.vin = 1'b0;
        bus.sof = 1'b0;
    endtask

    // Flag vector: {vout_0, vout_1, vout_2, err}
    function automatic logic [3:0] flags();
        return {bus.vout_0, bus.vout_1, bus.vout_2, bus.err};
    endfunction

    function automatic logic [3*W-1:0] douts();
        return {bus.dout_0, bus.dout_1, bus.dout_2};
    endfunction

    task automatic test_reset();
        rst     = 1'b1;
        bus.vin = 1'b0;
        bus.sof = 1'b0;
        bus.din = '0;
        tick();
        tick();
        n_cmp++;
        if (flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want %b", flags(), 4'b0000);
        end
        n_cmp++;
        if (douts() !== 24'h000000) begin
            n_fail++;
            $display("FAIL reset_douts: got %h want %h", douts(), 24'h000000);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_gapped();
        send(8'sd5, 1'b0);
        n_cmp++;
        if (flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL gap_s0_flags: got %b want %b", flags(), 4'b0000);
        end
        tick();
        send(-8'sd3, 1'b0);
        tick();
        tick();
        n_cmp++;
        if (flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL gap_s1_flags: got %b want %b", flags(), 4'b0000);
        end
        send(8'sd7, 1'b0);
        n_cmp++;
        if (flags() !== 4'b1110) begin
            n_fail++;
            $display("FAIL gap_vout: got %b want %b", flags(), 4'b1110);
        end
        n_cmp++;
        if (douts() !== 24'h05FD07) begin
            n_fail++;
            $display("FAIL gap_douts: got %h want %h", douts(), 24'h05FD07);
        end
        tick();
        n_cmp++;
        if (flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL gap_vout_clear: got %b want %b", flags(), 4'b0000);
        end
        n_cmp++;
        if (douts() !== 24'h05FD07) begin
            n_fail++;
            $display("FAIL gap_douts_hold: got %h want %h", douts(), 24'h05FD07);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] want;
        bus.vin = 1'b1;
        bus.sof = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.din = W'(i);
            tick();
            want = (i == 3 || i == 6) ? 4'b1110 : 4'b0000;
            n_cmp++;
            if (flags() !== want) begin
                n_fail++;
                $display("FAIL b2b_flags[%0d]: got %b want %b", i, flags(), want);
            end
            if (i == 3) begin
                n_cmp++;
                if (douts() !== 24'h010203) begin
                    n_fail++;
                    $display("FAIL b2b_grp1: got %h want %h", douts(), 24'h010203);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if (douts() !== 24'h040506) begin
                    n_fail++;
                    $display("FAIL b2b_grp2: got %h want %h", douts(), 24'h040506);
                end
            end
        end
        bus.vin = 1'b0;
        tick();
    endtask

    task automatic test_sof_resync();
        send(8'sd10, 1'b0);
        send(8'sd20, 1'b0);
        n_cmp++;
        if (flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL resync_pre: got %b want %b", flags(), 4'b0000);
        end
        send(8'sd30, 1'b1);
        n_cmp++;
        if (flags() !== 4'b0001) begin
            n_fail++;
            $display("FAIL resync_err: got %b want %b", flags(), 4'b0001);
        end
        send(8'sd40, 1'b0);
        n_cmp++;
        if (flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL resync_err_clear: got %b want %b", flags(), 4'b0000);
        end
        send(8'sd50, 1'b0);
        n_cmp++;
        if (flags() !== 4'b1110) begin
            n_fail++;
            $display("FAIL resync_vout: got %b want %b", flags(), 4'b1110);
        end
        n_cmp++;
        if (douts() !== 24'h1E2832) begin
            n_fail++;
            $display("FAIL resync_douts: got %h want %h", douts(), 24'h1E2832);
        end
        tick();
    endtask

    task automatic test_sof_ignored();
        // sof without vin mid-group must neither error nor restart the group.
        send(8'sd11, 1'b0);
        bus.sof = 1'b1;
        tick();
        bus.sof = 1'b0;
        n_cmp++;
        if (flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL sof_novin_flags: got %b want %b", flags(), 4'b0000);
        end
        send(8'sd12, 1'b0);
        send(8'sd13, 1'b0);
        n_cmp++;
        if ({flags(), douts()} !== {4'b1110, 24'h0B0C0D}) begin
            n_fail++;
            $display("FAIL sof_novin_grp: got %b/%h want %b/%h", flags(), douts(),
                     4'b1110, 24'h0B0C0D);
        end
        tick();
    endtask

    task automatic test_reset_mid_group();
        send(8'sd9, 1'b0);
        send(8'sd8, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({flags(), douts()} !== {4'b0000, 24'h000000}) begin
            n_fail++;
            $display("FAIL rstmid_state: got %b/%h want %b/%h", flags(), douts(),
                     4'b0000, 24'h000000);
        end
        send(8'sd1, 1'b0);
        send(8'sd2, 1'b0);
        n_cmp++;
        if (flags() !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_early: got %b want %b", flags(), 4'b0000);
        end
        send(8'sd3, 1'b0);
        n_cmp++;
        if ({flags(), douts()} !== {4'b1110, 24'h010203}) begin
            n_fail++;
            $display("FAIL rstmid_grp: got %b/%h want %b/%h", flags(), douts(),
                     4'b1110, 24'h010203);
        end
        tick();
    endtask

    task automatic test_extremes();
        send(-8'sd128, 1'b0);
        send(8'sd127, 1'b0);
        send(8'sd0, 1'b0);
        n_cmp++;
        if ({flags(), douts()} !== {4'b1110, 24'h807F00}) begin
            n_fail++;
            $display("FAIL extremes: got %b/%h want %b/%h", flags(), douts(),
                     4'b1110, 24'h807F00);
        end
        tick();
    endtask

    task automatic test_rst_priority();
        // Partly fill a group, then assert rst together with vin and sof.
        send(8'sd21, 1'b0);
        rst     = 1'b1;
        bus.vin = 1'b1;
        bus.sof = 1'b1;
        bus.din = 8'sd22;
        tick();
        rst     = 1'b0;
        bus.vin = 1'b0;
        bus.sof = 1'b0;
        n_cmp++;
        if ({flags(), douts()} !== {4'b0000, 24'h000000}) begin
            n_fail++;
            $display("FAIL rst_prio: got %b/%h want %b/%h", flags(), douts(),
                     4'b0000, 24'h000000);
        end
        tick();
    endtask

    task automatic test_loopback();
        // Serializer model: one triple streamed on consecutive cycles with sof
        // marking channel 0, as a parallel_to_serial upstream would.
        logic signed [W-1:0] trip [3];
        trip[0] = 8'sd4;
        trip[1] = 8'sd5;
        trip[2] = 8'sd6;
        bus.vin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.din = trip[k];
            bus.sof = (k == 0);
            tick();
            if (k < 2) begin
                n_cmp++;
                if (flags() !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL loop_mid[%0d]: got %b want %b", k, flags(), 4'b0000);
                end
            end
        end
        bus.vin = 1'b0;
        bus.sof = 1'b0;
        n_cmp++;
        if ({flags(), douts()} !== {4'b1110, 24'h040506}) begin
            n_fail++;
            $display("FAIL loop_grp: got %b/%h want %b/%h", flags(), douts(),
                     4'b1110, 24'h040506);
        end
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_gapped();
        test_back_to_back();
        test_sof_resync();
        test_sof_ignored();
        test_reset_mid_group();
        test_extremes();
        test_rst_priority();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
